// File: rtl/f1_reaction_timer.sv
// F1 start-light reaction timer: arms on a full light build-up, then measures
// press latency after lights-out in prescaled ticks, flagging jump starts and timeouts.
module f1_reaction_timer #(
    parameter int CLK_PER_TICK = 1000,
    parameter int CNT_W        = 16,
    parameter int TIMEOUT      = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       lights_in,
    input  logic             btn,
    output logic [CNT_W-1:0] result,
    output logic             valid,
    output logic             jump_start,
    output logic             timeout,
    output logic             busy
);

    localparam int               PRE_W       = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLK_PER_TICK - 1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [7:0]       LIGHTS_FIRST = 8'h01;
    localparam logic [7:0]       LIGHTS_ALL   = 8'hFF;
    localparam logic [7:0]       LIGHTS_OUT   = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMING = 3'd1,
        ST_ALL_ON = 3'd2,
        ST_TIMING = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           state_r, state_next_s;
    logic             btn_q_r;
    logic [PRE_W-1:0] presc_r, presc_next_s;
    logic [CNT_W-1:0] count_r, count_next_s;
    logic [CNT_W-1:0] result_r, result_next_s;
    logic             valid_r, valid_next_s;
    logic             jump_r, jump_next_s;
    logic             timeout_r, timeout_next_s;
    logic             busy_r;
    logic             press_s;

    assign press_s = btn & ~btn_q_r;

    // Next-state and datapath update; every register holds unless a transition says otherwise.
    always_comb begin
        state_next_s   = state_r;
        presc_next_s   = presc_r;
        count_next_s   = count_r;
        result_next_s  = result_r;
        valid_next_s   = 1'b0;
        jump_next_s    = jump_r;
        timeout_next_s = timeout_r;
        case (state_r)
            ST_IDLE: begin
                if (lights_in == LIGHTS_FIRST) begin
                    state_next_s = ST_ARMING;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARMING: begin
                if (press_s) begin
                    state_next_s = ST_DONE;
                    jump_next_s  = 1'b1;
                end else if (lights_in == LIGHTS_ALL) begin
                    state_next_s = ST_ALL_ON;
                end else if (lights_in == LIGHTS_OUT) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ARMING;
                end
            end
            ST_ALL_ON: begin
                if (press_s) begin
                    state_next_s = ST_DONE;
                    jump_next_s  = 1'b1;
                end else if (lights_in == LIGHTS_OUT) begin
                    state_next_s = ST_TIMING;
                    presc_next_s = {PRE_W{1'b0}};
                    count_next_s = {CNT_W{1'b0}};
                end else begin
                    state_next_s = ST_ALL_ON;
                end
            end
            ST_TIMING: begin
                // A press wins over a same-cycle tick, so the pre-increment count is reported.
                if (press_s && (count_r < CNT_TIMEOUT)) begin
                    state_next_s  = ST_DONE;
                    result_next_s = count_r;
                    valid_next_s  = 1'b1;
                end else if (count_r == CNT_TIMEOUT) begin
                    state_next_s   = ST_DONE;
                    result_next_s  = CNT_TIMEOUT;
                    timeout_next_s = 1'b1;
                end else if (presc_r == PRE_LAST) begin
                    presc_next_s = {PRE_W{1'b0}};
                    count_next_s = count_r + CNT_W'(1);
                end else begin
                    presc_next_s = presc_r + PRE_W'(1);
                end
            end
            ST_DONE: begin
                if (lights_in == LIGHTS_FIRST) begin
                    state_next_s   = ST_ARMING;
                    jump_next_s    = 1'b0;
                    timeout_next_s = 1'b0;
                    result_next_s  = {CNT_W{1'b0}};
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            btn_q_r   <= 1'b0;
            presc_r   <= {PRE_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            result_r  <= {CNT_W{1'b0}};
            valid_r   <= 1'b0;
            jump_r    <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            btn_q_r   <= btn;
            presc_r   <= presc_next_s;
            count_r   <= count_next_s;
            result_r  <= result_next_s;
            valid_r   <= valid_next_s;
            jump_r    <= jump_next_s;
            timeout_r <= timeout_next_s;
            busy_r    <= (state_next_s == ST_TIMING);
        end
    end

    assign result     = result_r;
    assign valid      = valid_r;
    assign jump_start = jump_r;
    assign timeout    = timeout_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Self-checking bench for f1_reaction_timer: vector table, directed corner
// sequences, and randomized episodes against a cycle-count reference model.
module tb_f1_reaction_timer;

    localparam int CPT = 4;
    localparam int TO  = 20;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    lights_in;
    logic          btn;
    logic [CW-1:0] result;
    logic          valid;
    logic          jump_start;
    logic          timeout;
    logic          busy;

    always #5 clk = ~clk;

    f1_reaction_timer #(
        .CLK_PER_TICK(CPT),
        .CNT_W       (CW),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lights_in (lights_in),
        .btn       (btn),
        .result    (result),
        .valid     (valid),
        .jump_start(jump_start),
        .timeout   (timeout),
        .busy      (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: phase 0 idle, 1 arming, 2 all-on, 3 timing, 4 done.
    // The tick count is derived from elapsed cycles since lights-out.
    int m_mode   = 0;
    int m_result = 0;
    bit m_valid  = 1'b0;
    bit m_jump   = 1'b0;
    bit m_tmo    = 1'b0;
    bit m_prev   = 1'b0;
    int m_cyc    = 0;
    int m_t0     = 0;

    typedef struct {
        bit         rst;
        logic [7:0] lights;
        bit         btn;
        int         res;
        bit         v;
        bit         j;
        bit         t;
        bit         bz;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [7:0] l, bit b, int res, bit v, bit j, bit t, bit bz);
        vec_t x;
        x.rst = r; x.lights = l; x.btn = b;
        x.res = res; x.v = v; x.j = j; x.t = t; x.bz = bz;
        return x;
    endfunction

    function automatic void model_step(bit r, logic [7:0] l, bit b);
        bit press;
        int cnt;
        press   = b && !m_prev;
        m_valid = 1'b0;
        if (r) begin
            m_mode = 0; m_result = 0; m_jump = 1'b0; m_tmo = 1'b0; m_prev = 1'b0;
        end else begin
            case (m_mode)
                0: if (l == 8'h01) m_mode = 1;
                1: begin
                    if (press) begin m_jump = 1'b1; m_mode = 4; end
                    else if (l == 8'hFF) m_mode = 2;
                    else if (l == 8'h00) m_mode = 0;
                end
                2: begin
                    if (press) begin m_jump = 1'b1; m_mode = 4; end
                    else if (l == 8'h00) begin m_mode = 3; m_t0 = m_cyc + 1; end
                end
                3: begin
                    cnt = (m_cyc - m_t0) / CPT;
                    if (cnt > TO) cnt = TO;
                    if (press && cnt < TO) begin
                        m_result = cnt; m_valid = 1'b1; m_mode = 4;
                    end else if (cnt == TO) begin
                        m_result = TO; m_tmo = 1'b1; m_mode = 4;
                    end
                end
                4: if (l == 8'h01) begin
                    m_jump = 1'b0; m_tmo = 1'b0; m_result = 0; m_mode = 1;
                end
                default: m_mode = 0;
            endcase
            m_prev = b;
        end
        m_cyc++;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic expect_out(input string tag, input int res, input bit v, input bit j,
                              input bit t, input bit bz);
        check({tag, ".result"},     {16'h0, result}, res);
        check({tag, ".valid"},      {31'h0, valid}, {31'h0, v});
        check({tag, ".jump_start"}, {31'h0, jump_start}, {31'h0, j});
        check({tag, ".timeout"},    {31'h0, timeout}, {31'h0, t});
        check({tag, ".busy"},       {31'h0, busy}, {31'h0, bz});
    endtask

    // Apply one cycle of inputs; outputs are then sampled 1 time unit after the edge.
    task automatic step(input bit r, input logic [7:0] l, input bit b);
        rst = r; lights_in = l; btn = b;
        @(posedge clk);
        #1;
        model_step(r, l, b);
    endtask

    task automatic to_timing(input bit b);
        logic [7:0] th;
        th = 8'h01;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, th, b);
            th = {th[6:0], 1'b1};
        end
        step(1'b0, 8'h00, b);
    endtask

    task automatic rstep(input logic [7:0] l, input bit b);
        bit r;
        r = ($urandom_range(0, 299) == 0);
        step(r, l, b);
        expect_out("rand", m_result, m_valid, m_jump, m_tmo, m_mode == 3);
    endtask

    initial begin
        logic [7:0] th;
        bit saw_v;
        rst = 1'b1; lights_in = 8'h00; btn = 1'b0;

        // ---- vector table: reset, normal run, jump start ----
        vecs.push_back(mk(1'b1, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        th = 8'h01;
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1'b0, th, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
            th = {th[6:0], 1'b1};
        end
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0));
        th = 8'h01;
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(1'b0, th, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
            th = {th[6:0], 1'b1};
        end
        vecs.push_back(mk(1'b0, 8'h1F, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h3F, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h7F, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'hFF, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h01, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].lights, vecs[i].btn);
            expect_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].v, vecs[i].j,
                       vecs[i].t, vecs[i].bz);
        end

        // ---- timeout: no press, flag at T0+81 ----
        to_timing(1'b0);
        saw_v = 1'b0;
        for (int k = 0; k < 80; k++) begin
            step(1'b0, 8'h00, 1'b0);
            if (valid) saw_v = 1'b1;
        end
        check("tmo.busy_at_80", {31'h0, busy}, 32'd1);
        check("tmo.flag_at_80", {31'h0, timeout}, 32'd0);
        step(1'b0, 8'h00, 1'b0);
        expect_out("tmo", TO, 1'b0, 1'b0, 1'b1, 1'b0);
        check("tmo.no_valid", {31'h0, saw_v}, 32'd0);
        step(1'b0, 8'h01, 1'b0);
        expect_out("tmo.clear", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // ---- abort then rerun with press at T0+5 ----
        step(1'b0, 8'h01, 1'b0);
        step(1'b0, 8'h03, 1'b0);
        step(1'b0, 8'h07, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        expect_out("abort", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        expect_out("abort.idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        to_timing(1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        expect_out("rerun", 1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("rerun.valid_pulse", {31'h0, valid}, 32'd0);
        step(1'b0, 8'h01, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // ---- button held high throughout: never a press ----
        step(1'b0, 8'h00, 1'b1);
        to_timing(1'b1);
        saw_v = 1'b0;
        for (int k = 0; k < 80; k++) begin
            step(1'b0, 8'h00, 1'b1);
            if (valid) saw_v = 1'b1;
        end
        step(1'b0, 8'h00, 1'b1);
        expect_out("held", TO, 1'b0, 1'b0, 1'b1, 1'b0);
        check("held.no_valid", {31'h0, saw_v}, 32'd0);
        step(1'b0, 8'h01, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // ---- press on the tick cycle T0+7 captures pre-increment count ----
        to_timing(1'b0);
        for (int k = 0; k < 7; k++) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        expect_out("collide", 1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h01, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // ---- reset at T0+6, then stale 00/FF lights ignored ----
        to_timing(1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 8'h00, 1'b0);
        check("rst.busy_before", {31'h0, busy}, 32'd1);
        step(1'b1, 8'h00, 1'b0);
        expect_out("rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        expect_out("rst.idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // ---- randomized episodes against the reference model ----
        step(1'b1, 8'h00, 1'b0);
        for (int ep = 0; ep < 40; ep++) begin
            bit bl;
            int pr;
            int wl;
            bl = 1'b0;
            th = 8'h01;
            for (int i = 0; i < 8; i++) begin
                int hold;
                hold = $urandom_range(1, 3);
                for (int h = 0; h < hold; h++) begin
                    if ($urandom_range(0, 39) == 0) bl = ~bl;
                    rstep(th, bl);
                end
                if ($urandom_range(0, 9) == 0) rstep(8'h5A, bl);
                if ($urandom_range(0, 15) == 0) rstep(8'h00, bl);
                th = {th[6:0], 1'b1};
            end
            pr = $urandom_range(0, 100);
            wl = $urandom_range(20, 95);
            for (int j = 0; j < wl; j++)
                rstep(8'h00, (j >= pr && j < pr + 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
